// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer for the 5-stage RV32 pipeline: per-latch enable/flush and PC enable.
// Define PIPE_PERF_EN to build the saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int REGBITS = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               dREN_mem,
  input  logic               dWEN_mem,
  input  logic               halt_mem,
  input  logic               halt_wb,
  input  logic [REGBITS-1:0] rs1_id,
  input  logic [REGBITS-1:0] rs2_id,
  input  logic [REGBITS-1:0] rd_ex,
  input  logic               memtoreg_ex,
  input  logic               WEN_ex,
  input  logic               redirect_ex,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               exmem_flush,
  output logic               memwb_flush,
  output logic               halted,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
);

  typedef enum logic [1:0] {RUN, DSTALL, DRAIN, HALTED} state_t;

  state_t r_state, w_next;
  logic   w_dpend, w_loaduse;

  assign w_dpend   = (dREN_mem | dWEN_mem) & ~dhit;
  assign w_loaduse = memtoreg_ex & WEN_ex & (rd_ex != '0) &
                     ((rd_ex == rs1_id) | (rd_ex == rs2_id));

  always_ff @(posedge CLK) begin
    if (RST) r_state <= RUN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    pc_en       = ihit;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    if (RST) begin
      w_next      = RUN;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (r_state == HALTED || halt_wb) begin
      // halt reaching WB freezes everything, ahead of any hazard
      w_next   = HALTED;
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      halted   = (r_state == HALTED);
    end else if (r_state == DRAIN) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end else if (w_dpend) begin
      w_next      = DSTALL;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else begin
      // RUN, or the dhit cycle of DSTALL: a held-off redirect is honoured here
      w_next = (r_state == RUN && halt_mem) ? DRAIN : RUN;
      if (redirect_ex) begin
        pc_en      = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_loaduse) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;
  logic        w_any_flush;

  assign w_any_flush = ifid_flush | idex_flush | exmem_flush | memwb_flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && r_state != HALTED && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_any_flush && r_flush_cnt != '1)                 r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
